md_sched: RTL and testbench

- Multi-cycle multiply/divide scheduler attached to the EX stage of the pipelined CPU.
- Captures an MDU operation when the instruction reaches EX and holds HI/LO.
- Models the fixed mult/div latency with a countdown counter and raises a stall request for the decode-stage hazard logic while the MDU is busy.
- Gives mfhi/mflo/mthi/mtlo and back-to-back mult/div a single sequencing point.

---
 rtl/md_sched_pkg.sv | 31 +++
 rtl/md_arith.sv | 59 +++++
 rtl/md_sched.sv | 109 ++++++++++
 tb/tb_md_sched.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/md_sched_pkg.sv
// Shared definitions for the multiply/divide scheduler: op encodings, default
// latencies, field widths and FSM state type.
package md_sched_pkg;

    localparam int OP_W          = 3;
    localparam int DATA_W        = 32;
    localparam int MULT_CYC_DEF  = 5;
    localparam int DIV_CYC_DEF   = 10;

    localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // mult/multu/div/divu occupy the unit; the move ops and reserved codes do not
    function automatic logic is_md_op(input logic [OP_W-1:0] op);
        return (op[2] == 1'b0);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: signed/unsigned 32x32 products and
// quotient/remainder, packed as {hi, lo}; flags a zero divisor.
module md_arith
    import md_sched_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res_hi,
    output logic [DATA_W-1:0] res_lo,
    output logic              div_zero
);

    logic              sgn;
    logic              a_neg;
    logic              b_neg;
    logic [63:0]       ax;
    logic [63:0]       bx;
    logic [63:0]       prod;
    logic [DATA_W-1:0] a_mag;
    logic [DATA_W-1:0] b_mag;
    logic [DATA_W-1:0] q_mag;
    logic [DATA_W-1:0] r_mag;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] rem;

    always_comb begin
        sgn   = (op == MD_MULT) || (op == MD_DIV);
        a_neg = sgn & a[DATA_W-1];
        b_neg = sgn & b[DATA_W-1];

        // Sign-extend to 64 bits so one unsigned multiply serves both flavours
        ax   = {{DATA_W{a_neg}}, a};
        bx   = {{DATA_W{b_neg}}, b};
        prod = ax * bx;

        // Divide on magnitudes to sidestep the INT_MIN / -1 overflow case
        a_mag = a_neg ? (~a + 32'd1) : a;
        b_mag = b_neg ? (~b + 32'd1) : b;
        q_mag = '0;
        r_mag = '0;
        if (b_mag != '0) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quo = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        rem = a_neg ? (~r_mag + 32'd1) : r_mag;

        div_zero = is_div_op(op) && (b == '0);
        if (is_div_op(op)) begin
            res_hi = rem;
            res_lo = quo;
        end else begin
            res_hi = prod[63:32];
            res_lo = prod[31:0];
        end
    end

endmodule

// File: rtl/md_sched.sv
// Multi-cycle mult/div scheduler: captures the op in EX, counts down its latency,
// commits HI/LO and requests decode stalls. MDU_EARLY_OUT_EN enables zero-operand early out.
module md_sched
    import md_sched_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYC_DEF,
    parameter int DIV_CYCLES  = DIV_CYC_DEF,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              md_use_d,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output md_state_e         state_dbg
);

    md_state_e         state;
    md_state_e         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  load_cnt;
    logic [DATA_W-1:0] pend_hi;
    logic [DATA_W-1:0] pend_lo;
    logic              pend_keep;
    logic [DATA_W-1:0] res_hi;
    logic [DATA_W-1:0] res_lo;
    logic              div_zero;
    logic              launch;

    md_arith u_arith (
        .op       (op),
        .a        (a),
        .b        (b),
        .res_hi   (res_hi),
        .res_lo   (res_lo),
        .div_zero (div_zero)
    );

    assign busy      = (state == ST_RUN);
    assign launch    = start && (state == ST_IDLE) && is_md_op(op);
    assign stall     = md_use_d && (busy || (start && is_md_op(op)));
    assign state_dbg = state;

    always_comb begin
        load_cnt = is_div_op(op) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
`ifdef MDU_EARLY_OUT_EN
        if (is_div_op(op) ? (b == '0) : ((a == '0) || (b == '0)))
            load_cnt = '0;
`else
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (launch) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == '0) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            pend_hi   <= '0;
            pend_lo   <= '0;
            pend_keep <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (launch) begin
                    pend_hi   <= res_hi;
                    pend_lo   <= res_lo;
                    pend_keep <= div_zero;
                    cnt       <= load_cnt;
                end else if (start && op == MD_MTHI) begin
                    hi <= a;
                end else if (start && op == MD_MTLO) begin
                    lo <= a;
                end
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end else begin
                // A zero divisor leaves HI/LO untouched but still completes
                if (!pend_keep) begin
                    hi <= pend_hi;
                    lo <= pend_lo;
                end
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_md_sched.sv
// Directed table-driven bench for md_sched: latency, arithmetic, stall, move ops,
// divide-by-zero and asynchronous reset abort.
module tb_md_sched;
    import md_sched_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_use_d;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    md_state_e   state_dbg;

    int checks = 0;
    int fails  = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        use_d;
        logic [31:0] ehi;
        logic [31:0] elo;
        string       name;
    } vec_t;

    vec_t vecs[15];

    md_sched dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .md_use_d  (md_use_d),
        .busy      (busy),
        .stall     (stall),
        .done      (done),
        .hi        (hi),
        .lo        (lo),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issuing while busy is prevented by the stall and must never be seen
    always @(negedge clk) begin
        if (reset && start && busy) begin
            fails++;
            $display("FAIL start_while_busy: start=1 seen with busy=1 at %0t", $time);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic int lat(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
`ifdef MDU_EARLY_OUT_EN
        if ((o == MD_DIV || o == MD_DIVU) && y == 0) return 1;
        if ((o == MD_MULT || o == MD_MULTU) && (x == 0 || y == 0)) return 1;
`endif
        return (o == MD_DIV || o == MD_DIVU) ? 10 : 5;
    endfunction

    // mult/div: count busy cycles, locate the done pulse, watch the stall output
    task automatic run_md(input vec_t v);
        int nbusy = 0;
        int ndone = 0;
        int done_at = -1;
        int nstall_bad = 0;
        int ecyc;
        ecyc = lat(v.op, v.a, v.b);
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b; md_use_d = v.use_d;
        #1;
        chk({v.name, "_stall_issue"}, {31'd0, stall}, {31'd0, v.use_d});
        @(posedge clk);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (i == 0) begin
                chk({v.name, "_hi_hold"}, hi, exp_hi);
                chk({v.name, "_lo_hold"}, lo, exp_lo);
            end
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (done_at < 0) done_at = i;
            end
            if (stall !== (v.use_d & busy)) nstall_bad++;
        end
        md_use_d = 1'b0;
        exp_hi = v.ehi;
        exp_lo = v.elo;
        chk({v.name, "_busy_cycles"}, nbusy, ecyc);
        chk({v.name, "_done_count"}, ndone, 1);
        chk({v.name, "_done_pos"}, done_at, ecyc);
        chk({v.name, "_stall_track"}, nstall_bad, 0);
        chk({v.name, "_hi"}, hi, exp_hi);
        chk({v.name, "_lo"}, lo, exp_lo);
    endtask

    // move ops and reserved codes: effect on the next edge, never busy
    task automatic run_mv(input vec_t v);
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b; md_use_d = v.use_d;
        #1;
        chk({v.name, "_stall"}, {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; md_use_d = 1'b0;
        #1;
        exp_hi = v.ehi;
        exp_lo = v.elo;
        chk({v.name, "_busy"}, {31'd0, busy}, 32'd0);
        chk({v.name, "_done"}, {31'd0, done}, 32'd0);
        chk({v.name, "_hi"}, hi, exp_hi);
        chk({v.name, "_lo"}, lo, exp_lo);
    endtask

    initial begin
        vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA, "mult_neg"};
        vecs[1]  = '{MD_DIVU,  32'd17,       32'd5,        1'b0, 32'd2,        32'd3,        "divu_17_5"};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, "div_m7_2"};
        vecs[3]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h00000000, 32'h80000000, "div_ovf"};
        vecs[4]  = '{MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h3FFFFFFF, 32'h00000001, "mult_max"};
        vecs[5]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, "div_7_m2"};
        vecs[6]  = '{MD_DIVU,  32'hFFFFFFFF, 32'd10,       1'b0, 32'd5,        32'h19999999, "divu_big"};
        vecs[7]  = '{MD_MTHI,  32'h11,       32'd0,        1'b0, 32'h11,       32'h19999999, "mthi"};
        vecs[8]  = '{MD_MTLO,  32'h22,       32'd0,        1'b0, 32'h11,       32'h22,       "mtlo"};
        vecs[9]  = '{MD_DIV,   32'd5,        32'd0,        1'b0, 32'h11,       32'h22,       "div_by0"};
        vecs[10] = '{MD_MULTU, 32'd0,        32'h12345,    1'b0, 32'h0,        32'h0,        "multu_zero"};
        vecs[11] = '{MD_MULTU, 32'h0000FFFF, 32'h00010001, 1'b1, 32'h0,        32'hFFFFFFFF, "multu_stall"};
        vecs[12] = '{MD_MTLO,  32'h1234,     32'd0,        1'b1, 32'h0,        32'h1234,     "mtlo_idle"};
        vecs[13] = '{3'd6,     32'hDEAD,     32'hBEEF,     1'b0, 32'h0,        32'h1234,     "reserved"};
        vecs[14] = '{MD_DIVU,  32'd5,        32'd0,        1'b0, 32'h0,        32'h1234,     "divu_by0"};

        reset = 1'b0; start = 1'b0; op = '0; a = '0; b = '0; md_use_d = 1'b0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_state", {31'd0, state_dbg}, {31'd0, ST_IDLE});
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].op[2]) run_mv(vecs[i]);
            else               run_md(vecs[i]);
        end

        // Abort a MULT at its third busy cycle with reset
        @(negedge clk);
        start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd3; md_use_d = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #1;
        chk("abort_busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        reset = 1'b1; md_use_d = 1'b0;
        run_md('{MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 32'h1, 32'hFFFFFFFE, "multu_after_rst"});

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
